payload_match_collector: RTL and testbench
==========================================

PAYLOAD_MATCH_COLLECTOR -- requirements
Module: payload_match_collector

Interface
REQ-001 SHALL have parameter N_ENG, default 16, meaning the number of engine match inputs (2..256).
REQ-002 SHALL have parameter ID_W, default 8, meaning the width of the reported engine ID (2**ID_W >= N_ENG).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sod, input, 1 bit: start-of-data pulse; the same signal clears the engines.
REQ-006 SHALL have port en, input, 1 bit: byte-valid strobe; the same signal feeds the engines' CE.
REQ-007 SHALL have port eod, input, 1 bit: end-of-data pulse, coincident with the en of the last payload byte.
REQ-008 SHALL have port eng_out, input, N_ENG bits: the sticky engine match outputs.
REQ-009 SHALL have port rpt_valid, output, 1 bit: a report word is available.
REQ-010 SHALL have port rpt_ready, input, 1 bit: the consumer accepts the report word.
REQ-011 SHALL have port rpt_id, output, ID_W bits: the index of a matched engine.
REQ-012 SHALL have port rpt_last, output, 1 bit: this report word is the last one for the packet.
REQ-013 SHALL have port pkt_done, output, 1 bit: one-cycle pulse when a packet's result has been fully handled.
REQ-014 SHALL have port pkt_match, output, 1 bit: valid with pkt_done; 1 means at least one engine matched.
REQ-015 SHALL have port overrun, output, 1 bit: one-cycle pulse when a packet result is dropped.

Function
REQ-016 SHALL implement the FSM states IDLE, ACTIVE, SETTLE, SCAN and DONE.
REQ-017 IDLE/DONE -> ACTIVE SHALL occur on sod; sod in ACTIVE SHALL restart the packet (stay in ACTIVE, no report).
REQ-018 ACTIVE -> SETTLE SHALL occur on the cycle eod and en are both 1; eod without en SHALL be ignored.
REQ-019 SETTLE SHALL last exactly 1 cycle (engine FDCE latency), then copy eng_out into the snapshot register and go to SCAN.
REQ-020 In SCAN with snapshot == 0, the block SHALL emit no report words, pulse pkt_done with pkt_match=0, and go to DONE.
REQ-021 In SCAN with snapshot != 0, rpt_valid SHALL be 1 and rpt_id SHALL be the lowest-index set snapshot bit.
REQ-022 rpt_last SHALL be 1 when exactly one snapshot bit remains set.
REQ-023 On rpt_valid & rpt_ready, the reported bit SHALL be cleared; the next ID SHALL be presented on the following cycle (one word per cycle at full throughput).
REQ-024 rpt_id and rpt_last SHALL stay stable while rpt_valid=1 and rpt_ready=0; rpt_valid SHALL NOT drop before acceptance.
REQ-025 On acceptance of the rpt_last word, the block SHALL pulse pkt_done with pkt_match=1 in that same cycle and go to DONE.
REQ-026 DONE SHALL behave as IDLE; the state exists only so a bench can observe completion.
REQ-027 sod during SETTLE or SCAN SHALL NOT disturb the snapshot or the report in progress; a pending-packet flag SHALL be set so that the next eod&en is tracked.
REQ-028 An eod&en arriving while the prior packet is still in SCAN SHALL pulse overrun and discard the new packet's result; the in-flight report SHALL complete unchanged.
REQ-029 After an overrun the FSM SHALL return to IDLE; a packet whose sod was absorbed as pending SHALL return to ACTIVE.
REQ-030 Simultaneous sod and eod&en in ACTIVE SHALL be treated as eod first (go to SETTLE), with sod recorded as pending.
REQ-031 eng_out SHALL be sampled only in SETTLE; engine changes at any other time SHALL be ignored.

Reset
REQ-032 On rst the FSM SHALL enter IDLE and the snapshot and pending flag SHALL clear.
REQ-033 On rst rpt_valid, rpt_last, pkt_done, pkt_match and overrun SHALL be 0, and rpt_id SHALL be 0.
REQ-034 rst mid-SCAN SHALL abort the report without a pkt_done pulse; rst SHALL take priority over all inputs.

Structure
REQ-035 The FSM state encoding and the ID_W derivation function SHALL be in the shared package payload_engine_pkg.
REQ-036 A single sub-module, lowest_set_encoder (combinational: N_ENG vector to index plus a one-hot-remaining flag), SHALL be instantiated once.
REQ-037 All state SHALL be flip-flops; no memories.

Verification
REQ-038 Bench: sod, 5 bytes, eod&en with eng_out=0 -> after SETTLE, pkt_done=1, pkt_match=0, no rpt_valid.
REQ-039 Bench: eng_out=0x0092, rpt_ready=1 -> rpt_id 1, 4, 7 on consecutive cycles; rpt_last only with 7; pkt_done with 7.
REQ-040 Bench: eng_out=0x8001, rpt_ready held 0 for 3 cycles -> rpt_id=0 stable for 3 cycles, then 0 and 15 (last).
REQ-041 Bench: second sod plus eod&en during SCAN of the first packet -> overrun pulse 1 cycle; the first packet's report is intact.
REQ-042 Bench: rst asserted mid-SCAN -> next cycle rpt_valid=0, state IDLE, no pkt_done.
REQ-043 Bench: eng_out changes after SETTLE -> report reflects the sampled value only.

Source files
------------

// File: rtl/payload_engine_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : payload_engine_pkg
// Purpose  : Shared FSM encoding and ID width helper for the match collector.
// Revision : 1.0
// ---------------------------------------------------------------------------
package payload_engine_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_state_w-1:0] c_st_active = 3'd1;
    localparam logic [c_state_w-1:0] c_st_settle = 3'd2;
    localparam logic [c_state_w-1:0] c_st_scan   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_done   = 3'd4;

    // Smallest index width able to address n engines (at least 1 bit).
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_set_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lowest_set_encoder
// Purpose  : Index of the lowest set bit plus "any" and "exactly one" flags.
// Revision : 1.0
// ---------------------------------------------------------------------------
module lowest_set_encoder #(
    parameter int N_ENG = 16,
    parameter int IDX_W = 4
) (
    input  logic [N_ENG-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_one_left
);

    always_comb begin
        o_idx = '0;
        // Descending scan so the lowest set bit is the final assignment.
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
        end
    end

    always_comb begin
        o_any      = |i_vec;
        o_one_left = o_any && ((i_vec & (i_vec - {{(N_ENG-1){1'b0}}, 1'b1})) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/payload_match_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : payload_match_collector
// Purpose  : Snapshots sticky engine matches at end of payload and streams
//            the matched engine IDs out, lowest index first.
// Revision : 1.0
// ---------------------------------------------------------------------------
module payload_match_collector
    import payload_engine_pkg::*;
#(
    parameter int N_ENG = 16,
    parameter int ID_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sod,
    input  logic             en,
    input  logic             eod,
    input  logic [N_ENG-1:0] eng_out,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [ID_W-1:0]  rpt_id,
    output logic             rpt_last,
    output logic             pkt_done,
    output logic             pkt_match,
    output logic             overrun
);

    localparam int c_idx_w = id_width(N_ENG);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nx;
    logic [N_ENG-1:0]     r_snap;
    logic                 r_pending;
    logic                 r_dropped;
    logic                 r_overrun;

    logic [c_idx_w-1:0]   w_idx;
    logic                 w_any;
    logic                 w_one_left;
    logic                 w_byte_end;
    logic                 w_busy;
    logic                 w_overrun;
    logic                 w_accept;
    logic                 w_finish;
    logic                 w_pend_keep;

    lowest_set_encoder #(
        .N_ENG (N_ENG),
        .IDX_W (c_idx_w)
    ) u_enc (
        .i_vec      (r_snap),
        .o_idx      (w_idx),
        .o_any      (w_any),
        .o_one_left (w_one_left)
    );

    always_comb begin
        w_byte_end = eod & en;
        w_busy     = (r_state == c_st_settle) || (r_state == c_st_scan);
        // A second packet's end while the first is still reporting is dropped.
        w_overrun  = w_busy & r_pending & w_byte_end;
        w_accept   = (r_state == c_st_scan) & w_any & rpt_ready;
        w_finish   = (r_state == c_st_scan) & (~w_any | (w_accept & w_one_left));
    end

    always_comb begin
        w_pend_keep = 1'b0;
        case (r_state)
            c_st_active: w_pend_keep = sod & w_byte_end;
            c_st_settle,
            c_st_scan:   w_pend_keep = w_overrun ? sod : (r_pending | sod);
            default:     w_pend_keep = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle,
            c_st_done:   if (sod) w_state_nx = c_st_active;
            c_st_active: if (w_byte_end) w_state_nx = c_st_settle;
            c_st_settle: w_state_nx = c_st_scan;
            c_st_scan: begin
                if (w_finish) begin
                    if (w_pend_keep)                w_state_nx = c_st_active;
                    else if (r_dropped | w_overrun) w_state_nx = c_st_idle;
                    else                            w_state_nx = c_st_done;
                end
            end
            default:     w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap    <= '0;
            r_pending <= 1'b0;
            r_dropped <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= w_pend_keep & ~w_finish;
            r_overrun <= w_overrun;
            if (w_finish)       r_dropped <= 1'b0;
            else if (w_overrun) r_dropped <= 1'b1;
            // Engines have one cycle of latency, so sample only in SETTLE.
            if (r_state == c_st_settle) r_snap <= eng_out;
            else if (w_accept)          r_snap <= r_snap & (r_snap - {{(N_ENG-1){1'b0}}, 1'b1});
        end
    end

    // Output logic
    always_comb begin
        rpt_valid = 1'b0;
        rpt_id    = '0;
        rpt_last  = 1'b0;
        pkt_done  = 1'b0;
        pkt_match = 1'b0;
        overrun   = r_overrun & ~rst;
        if (!rst && (r_state == c_st_scan)) begin
            rpt_valid = w_any;
            rpt_id    = w_any ? ID_W'(w_idx) : '0;
            rpt_last  = w_one_left;
            pkt_done  = w_finish;
            pkt_match = w_finish & w_any;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_payload_match_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_payload_match_collector
// Purpose  : Directed self-checking bench for payload_match_collector.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_payload_match_collector;
    import payload_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sod = 1'b0;
    logic        en = 1'b0;
    logic        eod = 1'b0;
    logic [15:0] eng_out = 16'h0;
    logic        rpt_ready = 1'b0;
    logic        rpt_valid;
    logic [7:0]  rpt_id;
    logic        rpt_last;
    logic        pkt_done;
    logic        pkt_match;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    payload_match_collector #(.N_ENG(16), .ID_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sod       (sod),
        .en        (en),
        .eod       (eod),
        .eng_out   (eng_out),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_id    (rpt_id),
        .rpt_last  (rpt_last),
        .pkt_done  (pkt_done),
        .pkt_match (pkt_match),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives sod, nbytes payload bytes (last one with eod) and leaves the bench
    // 1ns into the SETTLE cycle with en/eod released.
    task automatic start_pkt(input int nbytes, input logic [15:0] eng);
        step();
        sod = 1'b1;
        step();
        sod = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            en  = 1'b1;
            eod = (i == nbytes - 1);
            if (i == nbytes - 1) eng_out = eng;
            step();
        end
        en  = 1'b0;
        eod = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rpt_valid); end
        checks++; if (rpt_id !== 8'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rpt_id); end
        checks++; if (rpt_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", rpt_last); end
        checks++; if (pkt_done !== 1'b0 || pkt_match !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b exp 00", pkt_done, pkt_match); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (dut.r_state !== c_st_idle) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.r_state, c_st_idle); end
        rst = 1'b0;
    endtask

    task automatic test_no_match();
        rpt_ready = 1'b1;
        start_pkt(5, 16'h0000);
        #1;
        checks++; if (dut.r_state !== c_st_settle) begin errors++; $display("FAIL nomatch_settle got %0d exp %0d", dut.r_state, c_st_settle); end
        checks++; if (pkt_done !== 1'b0 || rpt_valid !== 1'b0) begin errors++; $display("FAIL nomatch_settle_out got done=%b valid=%b exp 0 0", pkt_done, rpt_valid); end
        step(); #1;
        checks++; if (pkt_done !== 1'b1 || pkt_match !== 1'b0) begin errors++; $display("FAIL nomatch_done got done=%b match=%b exp 1 0", pkt_done, pkt_match); end
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL nomatch_valid got %b exp 0", rpt_valid); end
        step(); #1;
        checks++; if (dut.r_state !== c_st_done || pkt_done !== 1'b0) begin errors++; $display("FAIL nomatch_after got state=%0d done=%b exp %0d 0", dut.r_state, pkt_done, c_st_done); end
    endtask

    task automatic test_multi_match();
        logic [7:0] exp_ids [3];
        exp_ids = '{8'd1, 8'd4, 8'd7};
        rpt_ready = 1'b1;
        start_pkt(3, 16'h0092);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            checks++; if (rpt_valid !== 1'b1 || rpt_id !== exp_ids[k]) begin errors++; $display("FAIL multi_id%0d got valid=%b id=%0d exp 1 %0d", k, rpt_valid, rpt_id, exp_ids[k]); end
            checks++; if (rpt_last !== (k == 2) || pkt_done !== (k == 2)) begin errors++; $display("FAIL multi_last%0d got last=%b done=%b exp %b", k, rpt_last, pkt_done, (k == 2)); end
        end
        checks++; if (pkt_match !== 1'b1) begin errors++; $display("FAIL multi_match got %b exp 1", pkt_match); end
        step(); #1;
        checks++; if (rpt_valid !== 1'b0 || dut.r_state !== c_st_done) begin errors++; $display("FAIL multi_end got valid=%b state=%0d exp 0 %0d", rpt_valid, dut.r_state, c_st_done); end
    endtask

    task automatic test_backpressure();
        rpt_ready = 1'b0;
        start_pkt(2, 16'h8001);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            checks++; if (rpt_valid !== 1'b1 || rpt_id !== 8'd0 || rpt_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got valid=%b id=%0d last=%b exp 1 0 0", k, rpt_valid, rpt_id, rpt_last); end
        end
        step();
        rpt_ready = 1'b1;
        #1;
        checks++; if (rpt_id !== 8'd0 || pkt_done !== 1'b0) begin errors++; $display("FAIL bp_accept0 got id=%0d done=%b exp 0 0", rpt_id, pkt_done); end
        step(); #1;
        checks++; if (rpt_id !== 8'd15 || rpt_last !== 1'b1 || pkt_done !== 1'b1 || pkt_match !== 1'b1) begin errors++; $display("FAIL bp_last got id=%0d last=%b done=%b match=%b exp 15 1 1 1", rpt_id, rpt_last, pkt_done, pkt_match); end
        step(); #1;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_end got valid=%b exp 0", rpt_valid); end
    endtask

    task automatic test_eng_change();
        rpt_ready = 1'b1;
        start_pkt(4, 16'h0004);
        step();
        eng_out = 16'hFFFF;
        #1;
        checks++; if (rpt_id !== 8'd2 || rpt_last !== 1'b1 || pkt_done !== 1'b1) begin errors++; $display("FAIL engchg_id got id=%0d last=%b done=%b exp 2 1 1", rpt_id, rpt_last, pkt_done); end
        step(); #1;
        checks++; if (rpt_valid !== 1'b0 || dut.r_state !== c_st_done) begin errors++; $display("FAIL engchg_end got valid=%b state=%0d exp 0 %0d", rpt_valid, dut.r_state, c_st_done); end
        eng_out = 16'h0000;
    endtask

    task automatic test_active_edge_cases();
        rpt_ready = 1'b1;
        step();
        sod = 1'b1;
        step();
        sod = 1'b0;
        eod = 1'b1;
        en  = 1'b0;
        step();
        eod = 1'b0;
        sod = 1'b1;
        #1;
        checks++; if (dut.r_state !== c_st_active) begin errors++; $display("FAIL edge_eod_no_en got state=%0d exp %0d", dut.r_state, c_st_active); end
        step();
        #1;
        checks++; if (dut.r_state !== c_st_active || rpt_valid !== 1'b0) begin errors++; $display("FAIL edge_restart got state=%0d valid=%b exp %0d 0", dut.r_state, rpt_valid, c_st_active); end
        // Simultaneous sod and last byte: eod wins, sod is kept as pending.
        en = 1'b1;
        eod = 1'b1;
        eng_out = 16'h0002;
        step();
        sod = 1'b0;
        en  = 1'b0;
        eod = 1'b0;
        #1;
        checks++; if (dut.r_state !== c_st_settle) begin errors++; $display("FAIL edge_sod_eod got state=%0d exp %0d", dut.r_state, c_st_settle); end
        step(); #1;
        checks++; if (rpt_id !== 8'd1 || rpt_last !== 1'b1 || pkt_done !== 1'b1) begin errors++; $display("FAIL edge_report got id=%0d last=%b done=%b exp 1 1 1", rpt_id, rpt_last, pkt_done); end
        step(); #1;
        checks++; if (dut.r_state !== c_st_active) begin errors++; $display("FAIL edge_pending got state=%0d exp %0d", dut.r_state, c_st_active); end
        en = 1'b1;
        eod = 1'b1;
        eng_out = 16'h0000;
        step();
        en = 1'b0;
        eod = 1'b0;
        step(); #1;
        checks++; if (pkt_done !== 1'b1 || pkt_match !== 1'b0) begin errors++; $display("FAIL edge_second got done=%b match=%b exp 1 0", pkt_done, pkt_match); end
        step();
    endtask

    task automatic test_pending();
        rpt_ready = 1'b0;
        start_pkt(2, 16'h0001);
        step();
        sod = 1'b1;
        #1;
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 8'd0 || rpt_last !== 1'b1) begin errors++; $display("FAIL pend_first got valid=%b id=%0d last=%b exp 1 0 1", rpt_valid, rpt_id, rpt_last); end
        step();
        sod = 1'b0;
        rpt_ready = 1'b1;
        #1;
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL pend_done got %b exp 1", pkt_done); end
        step();
        rpt_ready = 1'b0;
        #1;
        checks++; if (dut.r_state !== c_st_active || rpt_valid !== 1'b0) begin errors++; $display("FAIL pend_active got state=%0d valid=%b exp %0d 0", dut.r_state, rpt_valid, c_st_active); end
        en = 1'b1;
        eod = 1'b1;
        eng_out = 16'h0008;
        step();
        en = 1'b0;
        eod = 1'b0;
        step(); #1;
        checks++; if (rpt_id !== 8'd3 || rpt_last !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL pend_report got id=%0d last=%b ovr=%b exp 3 1 0", rpt_id, rpt_last, overrun); end
        rpt_ready = 1'b1;
        step(); #1;
        checks++; if (dut.r_state !== c_st_done) begin errors++; $display("FAIL pend_end got state=%0d exp %0d", dut.r_state, c_st_done); end
    endtask

    task automatic test_overrun();
        rpt_ready = 1'b0;
        start_pkt(2, 16'h0030);
        step();
        sod = 1'b1;
        #1;
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 8'd4) begin errors++; $display("FAIL ovr_first got valid=%b id=%0d exp 1 4", rpt_valid, rpt_id); end
        step();
        sod = 1'b0;
        en = 1'b1;
        eod = 1'b1;
        eng_out = 16'h0001;
        #1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
        step();
        en = 1'b0;
        eod = 1'b0;
        #1;
        checks++; if (overrun !== 1'b1 || rpt_id !== 8'd4 || rpt_valid !== 1'b1) begin errors++; $display("FAIL ovr_pulse got ovr=%b id=%0d valid=%b exp 1 4 1", overrun, rpt_id, rpt_valid); end
        step();
        rpt_ready = 1'b1;
        #1;
        checks++; if (overrun !== 1'b0 || rpt_id !== 8'd4) begin errors++; $display("FAIL ovr_single got ovr=%b id=%0d exp 0 4", overrun, rpt_id); end
        step(); #1;
        checks++; if (rpt_id !== 8'd5 || rpt_last !== 1'b1 || pkt_done !== 1'b1 || pkt_match !== 1'b1) begin errors++; $display("FAIL ovr_last got id=%0d last=%b done=%b match=%b exp 5 1 1 1", rpt_id, rpt_last, pkt_done, pkt_match); end
        step(); #1;
        checks++; if (dut.r_state !== c_st_idle || rpt_valid !== 1'b0) begin errors++; $display("FAIL ovr_idle got state=%0d valid=%b exp %0d 0", dut.r_state, rpt_valid, c_st_idle); end
        eng_out = 16'h0000;
    endtask

    task automatic test_rst_mid_scan();
        rpt_ready = 1'b0;
        start_pkt(2, 16'h00F0);
        step(); #1;
        checks++; if (rpt_valid !== 1'b1 || rpt_id !== 8'd4) begin errors++; $display("FAIL rstscan_pre got valid=%b id=%0d exp 1 4", rpt_valid, rpt_id); end
        step();
        rst = 1'b1;
        rpt_ready = 1'b1;
        #1;
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rstscan_done got %b exp 0", pkt_done); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (rpt_valid !== 1'b0 || pkt_done !== 1'b0) begin errors++; $display("FAIL rstscan_out got valid=%b done=%b exp 0 0", rpt_valid, pkt_done); end
        checks++; if (dut.r_state !== c_st_idle) begin errors++; $display("FAIL rstscan_state got %0d exp %0d", dut.r_state, c_st_idle); end
        rpt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_multi_match();
        test_backpressure();
        test_eng_change();
        test_active_edge_cases();
        test_pending();
        test_overrun();
        test_rst_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
